// File: rtl/exec_divider_pkg.sv
// Shared types for the iterative execution-unit divider.
package exec_divider_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : exec_divider_pkg

// File: rtl/div_step.sv
// One restoring shift/subtract division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // Shift next dividend bit into the partial remainder, subtract if it fits
  always_comb begin
    partial = {rem_in, quo_in[WIDTH-1]};
    diff    = partial - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = partial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule : div_step

// File: rtl/exec_divider.sv
// Iterative signed/unsigned restoring divider, BITS_PER_CYCLE quotient bits per clock.
module exec_divider
  import exec_divider_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  output logic             in_hold,
  input  logic             out_hold,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             has_overflow
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] rem_r, rem_nx;
  logic [WIDTH-1:0] quo_r, quo_nx;
  logic [WIDTH-1:0] dvs_r, dvs_nx;
  logic             neg_q_r, neg_q_nx;
  logic             neg_r_r, neg_r_nx;
  logic             out_valid_nx;
  logic [WIDTH-1:0] quotient_nx, remainder_nx;
  logic             div_by_zero_nx, has_overflow_nx;

  logic             numer_neg, denom_neg, overflow_case;
  logic [WIDTH-1:0] numer_mag, denom_mag;

  logic [WIDTH-1:0] rem_chain [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_chain [BITS_PER_CYCLE+1];

  assign rem_chain[0] = rem_r;
  assign quo_chain[0] = quo_r;

  // Chain of restoring steps resolved within one clock
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_chain[g]),
      .quo_in  (quo_chain[g]),
      .divisor (dvs_r),
      .rem_out (rem_chain[g+1]),
      .quo_out (quo_chain[g+1])
    );
  end

  // Upstream must hold its operation while the unit is busy
  assign in_hold = in_valid && (state != IDLE);

  // Operand sign/magnitude split and special-case detection
  always_comb begin
    numer_neg     = is_signed & numer[WIDTH-1];
    denom_neg     = is_signed & denom[WIDTH-1];
    numer_mag     = numer_neg ? WIDTH'(-numer) : numer;
    denom_mag     = denom_neg ? WIDTH'(-denom) : denom;
    overflow_case = is_signed && (numer == MOST_NEG) && (denom == '1);
  end

  // Next-state and datapath updates
  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    rem_nx          = rem_r;
    quo_nx          = quo_r;
    dvs_nx          = dvs_r;
    neg_q_nx        = neg_q_r;
    neg_r_nx        = neg_r_r;
    out_valid_nx    = out_valid;
    quotient_nx     = quotient;
    remainder_nx    = remainder;
    div_by_zero_nx  = div_by_zero;
    has_overflow_nx = has_overflow;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (denom == '0) begin
            quotient_nx    = '1;
            remainder_nx   = numer;
            div_by_zero_nx = 1'b1;
            out_valid_nx   = 1'b1;
            state_nx       = DONE;
          end else if (overflow_case) begin
            quotient_nx     = numer;
            remainder_nx    = '0;
            has_overflow_nx = 1'b1;
            out_valid_nx    = 1'b1;
            state_nx        = DONE;
          end else begin
            rem_nx   = '0;
            quo_nx   = numer_mag;
            dvs_nx   = denom_mag;
            neg_q_nx = numer_neg ^ denom_neg;
            neg_r_nx = numer_neg;
            cnt_nx   = CNT_W'(N);
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        rem_nx = rem_chain[BITS_PER_CYCLE];
        quo_nx = quo_chain[BITS_PER_CYCLE];
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          quotient_nx  = neg_q_r ? WIDTH'(-quo_chain[BITS_PER_CYCLE])
                                 : quo_chain[BITS_PER_CYCLE];
          remainder_nx = neg_r_r ? WIDTH'(-rem_chain[BITS_PER_CYCLE])
                                 : rem_chain[BITS_PER_CYCLE];
          out_valid_nx = 1'b1;
          state_nx     = DONE;
        end
      end
      DONE: begin
        if (!out_hold) begin
          out_valid_nx    = 1'b0;
          div_by_zero_nx  = 1'b0;
          has_overflow_nx = 1'b0;
          state_nx        = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rem_r        <= '0;
      quo_r        <= '0;
      dvs_r        <= '0;
      neg_q_r      <= 1'b0;
      neg_r_r      <= 1'b0;
      out_valid    <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
      has_overflow <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      rem_r        <= rem_nx;
      quo_r        <= quo_nx;
      dvs_r        <= dvs_nx;
      neg_q_r      <= neg_q_nx;
      neg_r_r      <= neg_r_nx;
      out_valid    <= out_valid_nx;
      quotient     <= quotient_nx;
      remainder    <= remainder_nx;
      div_by_zero  <= div_by_zero_nx;
      has_overflow <= has_overflow_nx;
    end
  end

endmodule : exec_divider

// File: tb/tb_exec_divider.sv
// Scoreboard bench for exec_divider: BITS_PER_CYCLE=1 and =4 instances, WIDTH=32.
module tb_exec_divider;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid1, in_valid4, is_signed, out_hold;
  logic [31:0] numer, denom;
  logic        in_hold1, out_valid1, dz1, ov1;
  logic        in_hold4, out_valid4, dz4, ov4;
  logic [31:0] quotient1, remainder1, quotient4, remainder4;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  exec_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .is_signed(is_signed),
    .numer(numer), .denom(denom), .in_hold(in_hold1), .out_hold(out_hold),
    .out_valid(out_valid1), .quotient(quotient1), .remainder(remainder1),
    .div_by_zero(dz1), .has_overflow(ov1)
  );

  exec_divider #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid4), .is_signed(is_signed),
    .numer(numer), .denom(denom), .in_hold(in_hold4), .out_hold(out_hold),
    .out_valid(out_valid4), .quotient(quotient4), .remainder(remainder4),
    .div_by_zero(dz4), .has_overflow(ov4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check_res(input exp_t e, input logic [31:0] aq, input logic [31:0] ar,
                           input logic adz, input logic aov);
    chk({e.name, ".quotient"},  aq, e.q);
    chk({e.name, ".remainder"}, ar, e.r);
    chk({e.name, ".div_by_zero"},  32'(adz), 32'(e.dz));
    chk({e.name, ".has_overflow"}, 32'(aov), 32'(e.ov));
  endtask

  // Monitor for the 1-bit-per-cycle unit: compare each consumed result
  always @(negedge clock) begin
    if (reset_n && out_valid1 && !out_hold) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result1: got quotient 0x%h, expected no result", quotient1);
      end else begin
        e1 = q1.pop_front();
        check_res(e1, quotient1, remainder1, dz1, ov1);
      end
    end else if (!out_valid1 && (dz1 || ov1)) begin
      checks++; errors++;
      $display("FAIL flags_idle1: got dz=%0b ov=%0b, expected 0 0", dz1, ov1);
    end
  end

  // Monitor for the 4-bits-per-cycle unit
  always @(negedge clock) begin
    if (reset_n && out_valid4 && !out_hold) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result4: got quotient 0x%h, expected no result", quotient4);
      end else begin
        e4 = q4.pop_front();
        check_res(e4, quotient4, remainder4, dz4, ov4);
      end
    end else if (!out_valid4 && (dz4 || ov4)) begin
      checks++; errors++;
      $display("FAIL flags_idle4: got dz=%0b ov=%0b, expected 0 0", dz4, ov4);
    end
  end

  // Push the expectation and present the operation
  task automatic issue(input bit sel, input string name, input bit s,
                       input logic [31:0] n, input logic [31:0] d,
                       input logic [31:0] q, input logic [31:0] r,
                       input logic dz, input logic ov);
    exp_t e;
    e.name = name; e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    if (sel) q4.push_back(e); else q1.push_back(e);
    is_signed = s; numer = n; denom = d;
    if (sel) in_valid4 = 1'b1; else in_valid1 = 1'b1;
  endtask

  // Edges after the accepting edge until out_valid; direct results count 0
  task automatic wait_valid(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? out_valid4 : out_valid1) && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  // Full operation: issue, accept, wait, let the monitor consume
  task automatic run_op(input bit sel, input string name, input bit s,
                        input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] q, input logic [31:0] r,
                        input logic dz, input logic ov, input int exp_lat);
    int lat;
    issue(sel, name, s, n, d, q, r, dz, ov);
    @(posedge clock); #1;
    chk({name, ".in_hold"}, 32'(sel ? in_hold4 : in_hold1), 32'd1);
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    wait_valid(sel, lat);
    chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clock); #1;
    chk({name, ".drained"}, 32'(sel ? out_valid4 : out_valid1), 32'd0);
  endtask

  initial begin
    automatic int          lat;
    automatic bit          seen;
    automatic logic [31:0] rn, rd, rq, rr;
    automatic bit          rs;

    reset_n = 1'b1; in_valid1 = 1'b0; in_valid4 = 1'b0; out_hold = 1'b0;
    is_signed = 1'b0; numer = '0; denom = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset.out_valid", 32'(out_valid1), 32'd0);
    chk("reset.quotient",  quotient1, 32'd0);
    chk("reset.remainder", remainder1, 32'd0);
    chk("reset.flags",     32'({dz1, ov1}), 32'd0);
    chk("reset.in_hold",   32'(in_hold1), 32'd0);
    reset_n = 1'b1;

    // 1-bit-per-cycle directed vectors (first one accepted on first edge after reset)
    run_op(0, "u100_7",      0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 0, 32);
    run_op(0, "s_m7_2",      1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 0, 32);
    run_op(0, "u_fff9_2",    0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          0, 0, 32);
    run_op(0, "u5_0",        0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1, 0, 0);
    run_op(0, "s_ovf",       1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0, 1, 0);
    run_op(0, "s7_m2",       1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0, 0, 32);
    run_op(0, "s_m5_0",      1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1, 0, 0);
    run_op(0, "u_8000_ffff", 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  0, 0, 32);

    // Downstream stall with a new operation waiting upstream
    issue(0, "hold_op", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    wait_valid(0, lat);
    chk("hold_op.latency", 32'(lat), 32'd32);
    out_hold = 1'b1;
    issue(0, "after_hold", 0, 32'd1000, 32'd10, 32'd100, 32'd0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk("hold.quotient",  quotient1, 32'd14);
      chk("hold.remainder", remainder1, 32'd2);
      chk("hold.out_valid", 32'(out_valid1), 32'd1);
      chk("hold.in_hold",   32'(in_hold1), 32'd1);
    end
    out_hold = 1'b0;
    @(posedge clock); #1;
    chk("release.out_valid", 32'(out_valid1), 32'd0);
    chk("release.in_hold",   32'(in_hold1), 32'd0);
    @(posedge clock); #1;
    chk("after_hold.accepted", 32'(in_hold1), 32'd1);
    in_valid1 = 1'b0;
    wait_valid(0, lat);
    chk("after_hold.latency", 32'(lat), 32'd32);
    @(posedge clock); #1;

    // Reset in the middle of RUN discards the pending operation
    issue(0, "rst_op", 0, 32'd12345, 32'd3, 32'd4115, 32'd0, 0, 0);
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("midrun_reset.out_valid", 32'(out_valid1), 32'd0);
    chk("midrun_reset.quotient",  quotient1, 32'd0);
    chk("midrun_reset.remainder", remainder1, 32'd0);
    chk("midrun_reset.flags",     32'({dz1, ov1}), 32'd0);
    void'(q1.pop_back());
    @(posedge clock); #1;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (out_valid1) seen = 1'b1;
    end
    chk("post_reset.no_valid", 32'(seen), 32'd0);
    run_op(0, "u_ffff_1", 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0, 32);

    // 4-bits-per-cycle unit: directed vectors, 8-edge latency
    run_op(1, "b4_u1e6_999", 0, 32'd1000000,    32'd999,        32'd1001,       32'd1,          0, 0, 8);
    run_op(1, "b4_m100_7",   1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  0, 0, 8);
    run_op(1, "b4_100_m7",   1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          0, 0, 8);
    run_op(1, "b4_m100_m7",  1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  0, 0, 8);
    run_op(1, "b4_dead_16",  0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          0, 0, 8);
    run_op(1, "b4_min_2",    1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          0, 0, 8);
    run_op(1, "b4_3_5",      0, 32'd3,          32'd5,          32'd0,          32'd3,          0, 0, 8);
    run_op(1, "b4_max_m1",   1, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0001,  32'd0,          0, 0, 8);
    run_op(1, "b4_0_0",      0, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1, 0, 0);

    // 4-bits-per-cycle unit: random operands against the language's own divide
    for (int i = 0; i < 8; i++) begin
      rs = 1'(i % 2);
      rn = $urandom;
      rd = $urandom >> $urandom_range(0, 28);
      if (rd == 32'd0) rd = 32'd1;
      if (rs && rn == 32'h8000_0000 && rd == 32'hFFFF_FFFF) rd = 32'd3;
      if (rs) begin
        rq = 32'($signed(rn) / $signed(rd));
        rr = 32'($signed(rn) % $signed(rd));
      end else begin
        rq = rn / rd;
        rr = rn % rd;
      end
      run_op(1, $sformatf("b4_rand%0d", i), rs, rn, rd, rq, rr, 0, 0, 8);
    end

    chk("scoreboard_empty", 32'(q1.size() + q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the run never reaches its summary
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_exec_divider
